// File: rtl/mmff_pkg.sv
// mmff_pkg: definitions shared by the multi-mode flip-flop bank.
//   - 2-bit next-state mode encodings driven on in_mode
//   - legal WIDTH range, checked when the bank is elaborated
package mmff_pkg;

    localparam logic [1:0] MODE_LOAD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/mmff_cell.sv
// mmff_cell: next-state logic for one bit of the flip-flop bank.
// Ports:
//   mode      in   next-state select (LOAD / TOGGLE / SHIFT / COUNT)
//   d         in   parallel load bit
//   t         in   toggle mask bit
//   q         in   current state of this bit
//   q_left    in   state of the lower neighbour (serial input for bit 0)
//   carry_in  in   increment carry from the lower bits (1 for bit 0)
//   q_next    out  next state of this bit
//   carry_out out  increment carry into the next bit
module mmff_cell
    import mmff_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       d,
    input  logic       t,
    input  logic       q,
    input  logic       q_left,
    input  logic       carry_in,
    output logic       q_next,
    output logic       carry_out
);

    // Half-adder stage of the increment; only meaningful in COUNT mode,
    // the top gates the final carry by mode.
    assign carry_out = q & carry_in;

    always_comb begin
        q_next = q;
        case (mode)
            MODE_LOAD:   q_next = d;
            MODE_TOGGLE: q_next = q ^ t;
            MODE_SHIFT:  q_next = q_left;
            MODE_COUNT:  q_next = q ^ carry_in;
            default:     q_next = q;
        endcase
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH-bit flip-flop bank with per-cycle selectable
// next-state mode (load, per-bit toggle, serial shift, up-count).
// Parameters:
//   WIDTH      number of flip-flops (2..32)
//   RESET_VAL  value of Q after reset
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_en      update enable (0 holds Q, clears carry)
//   in_mode    00 LOAD, 01 TOGGLE, 10 SHIFT, 11 COUNT
//   in_D       parallel load data
//   in_T       toggle mask
//   in_ser     serial input, enters at bit 0
//   out_Q      registered state
//   out_QBar   ~out_Q
//   out_ser    out_Q[WIDTH-1]
//   out_carry  one-cycle pulse following a COUNT wrap to zero
//   out_parity ^out_Q, present only when MMFF_PARITY_EN is defined
module multi_mode_ff_bank
    import mmff_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_D,
    input  logic [WIDTH-1:0] in_T,
    input  logic             in_ser,
    output logic [WIDTH-1:0] out_Q,
    output logic [WIDTH-1:0] out_QBar,
    output logic             out_ser,
    output logic             out_carry
`ifdef MMFF_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
            $error("multi_mode_ff_bank: WIDTH out of legal range");
        end
    endgenerate

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] cell_q;
    logic [WIDTH-1:0] shift_src;
    // Ripple carry of the increment; cy[WIDTH] is the MSB of the
    // WIDTH+1-bit sum Q+1, i.e. the wrap indication.
    logic [WIDTH:0]   cy;

    assign cy[0]     = 1'b1;
    assign shift_src = {q_q[WIDTH-2:0], in_ser};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            mmff_cell u_cell (
                .mode      (in_mode),
                .d         (in_D[gi]),
                .t         (in_T[gi]),
                .q         (q_q[gi]),
                .q_left    (shift_src[gi]),
                .carry_in  (cy[gi]),
                .q_next    (cell_q[gi]),
                .carry_out (cy[gi+1])
            );
        end
    endgenerate

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        if (in_en) begin
            q_d     = cell_q;
            carry_d = (in_mode == MODE_COUNT) && cy[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q     <= RESET_VAL;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign out_Q     = q_q;
    assign out_QBar  = ~q_q;
    assign out_ser   = q_q[WIDTH-1];
    assign out_carry = carry_q;

`ifdef MMFF_PARITY_EN
    assign out_parity = ^q_q;
`endif

endmodule
